rv_mc_sequencer: RTL and testbench
==================================

// Module: rv_mc_sequencer
// PURPOSE
//  Multi-cycle control sequencer for the next-generation RV32 core. It replaces combinational
//  single-cycle sequencing with an FSM that talks to variable-latency instruction and data
//  memories over valid/ready handshakes. It owns PC, the instruction register, the load-data
//  register, and the PC/RF write strobes. It sits between the memory ports and the IDU/EXU/WBU.
// PARAMETERS
//  WIDTH     32            datapath/address width (32 or 64)
//  RESET_PC  32'h8000_0000 PC value loaded on reset
// PORTS
//  clk            in   1        core clock; all state updates on its rising edge
//  rst            in   1        asynchronous, active-high reset
//  imem_req_valid out  1        fetch request valid
//  imem_req_ready in   1        fetch request accepted
//  imem_addr      out  WIDTH    fetch address (= pc)
//  imem_rsp_valid in   1        fetch data valid
//  imem_rsp_data  in   32       fetched instruction
//  inst           out  32       instruction register, to IDU
//  dec_is_load    in   1        IDU: current inst is a load
//  dec_is_store   in   1        IDU: current inst is a store
//  dec_rf_wen     in   1        IDU: inst writes rd
//  dec_illegal    in   1        IDU: illegal opcode or ebreak
//  exu_next_pc    in   WIDTH    EXU: resolved next PC
//  exu_alu_result in   WIDTH    EXU: effective address for load/store
//  rf_rs2         in   WIDTH    store data
//  dm_wstrb_in    in   WIDTH/8  IDU: byte strobes
//  dmem_req_valid out  1        data request valid
//  dmem_req_ready in   1        data request accepted
//  dmem_req_we    out  1        1 = store, 0 = load
//  dmem_addr      out  WIDTH    data address
//  dmem_wdata     out  WIDTH    store data
//  dmem_wstrb     out  WIDTH/8  store byte strobes (all 0 on loads)
//  dmem_rsp_valid in   1        load data valid, or store acknowledged
//  dmem_rsp_data  in   WIDTH    load data
//  ld_data        out  WIDTH    load-data register, to WBU
//  rf_we          out  1        one-cycle regfile write strobe
//  pc             out  WIDTH    architectural PC
//  commit         out  1        one-cycle pulse when an instruction retires
//  halted         out  1        sticky; set on illegal/ebreak
// BEHAVIOUR
//  Reset values: state=FETCH_REQ, pc=RESET_PC, inst=32'h0000_0013 (nop), ld_data=0.
//   All strobes and valids are 0. halted=0.
//  FSM:
//   FETCH_REQ  imem_req_valid=1 -> FETCH_WAIT on imem_req_ready.
//   FETCH_WAIT on imem_rsp_valid: inst<=imem_rsp_data -> EXEC.
//   EXEC       (1 cycle, decode/ALU settle)
//              dec_illegal              -> HALT
//              dec_is_load|dec_is_store -> MEM_REQ
//              else                     -> WB
//   MEM_REQ    dmem_req_valid=1 -> MEM_WAIT on dmem_req_ready.
//              The address, data and strobes are captured into registers in EXEC.
//   MEM_WAIT   on dmem_rsp_valid: ld_data<=dmem_rsp_data (loads only) -> WB.
//   WB         rf_we=dec_rf_wen & ~dec_is_store, pc<=exu_next_pc, commit=1 -> FETCH_REQ.
//   HALT       absorbing; halted=1; no requests issued; only rst leaves it.
//  Handshake rules:
//   - A request is held with stable address/data until ready.
//   - Only one request is outstanding per port.
//   - A response is accepted only in the matching WAIT state, never in the handshake cycle.
//   - rsp_valid in any other state is ignored.
//  Latency: minimum 4 cycles for non-memory instructions; minimum 6 for load/store.
//   Each memory stall adds cycles 1:1.
//  pc[1:0] is never modified by this block. Misaligned exu_next_pc is passed through;
//   trapping is out of scope.
//  Reset mid-operation: abandons any in-flight request, returns to FETCH_REQ with
//   pc=RESET_PC. A stale response arrives outside a WAIT state and is therefore dropped.
// CONFIGURATION
//  YSYX_PERF_CNT_EN defined: adds two output ports.
//   - cyc_cnt (64 bits) counts every non-reset cycle, including HALT.
//   - instret_cnt (64 bits) increments on commit.
//   - Both reset to 0 and wrap modulo 2^64.
//  YSYX_PERF_CNT_EN undefined: neither port nor counter exists; behaviour is otherwise identical.
// STRUCTURE
//  Shared package rv_core_pkg:
//   - state enum: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT
//   - NOP_INST = 32'h0000_0013
//   - default RESET_PC
//  One sub-module, rv_perf_cnt, holds the two counters. It is instantiated only under the macro.
// TESTING
//  1 Reset: rst=1 -> pc=0x8000_0000, inst=0x00000013, all valids 0. Release -> imem_req_valid=1 next cycle.
//  2 addi with 0-wait memory: commit at cycle 4 after reset release, rf_we=1, pc=0x8000_0004.
//  3 lw, dmem ready delayed 3 cycles, rsp 2 cycles later:
//    dmem_addr is stable throughout; ld_data=0xDEAD_BEEF; commit after 6+5 cycles; rf_we=1.
//  4 sw with rf_rs2=0x1234_5678, wstrb=4'b1111: dmem_req_we=1, wdata matches; rf_we=0 at WB.
//  5 Branch with exu_next_pc=0x8000_0100: next imem_addr=0x8000_0100.
//    Spurious imem_rsp_valid pulsed in EXEC is ignored; inst is unchanged.
//  6 dec_illegal=1: halted=1, no further imem_req_valid.
//    rst pulsed during MEM_WAIT -> FETCH_REQ, late dmem_rsp dropped.
//    With YSYX_PERF_CNT_EN: instret_cnt equals the commit count.

Source files
------------

// File: rtl/rv_core_pkg.sv
// ============================================================================
//  Module      : rv_core_pkg
//  Description : Shared types and constants for the multi-cycle RV32 core
//                sequencer: FSM state encoding, NOP word and default reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_core_pkg;

  // Sequencer states, one per phase of an instruction's life.
  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    EXEC       = 3'd2,
    MEM_REQ    = 3'd3,
    MEM_WAIT   = 3'd4,
    WB         = 3'd5,
    HALT       = 3'd6
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/rv_perf_cnt.sv
// ============================================================================
//  Module      : rv_perf_cnt
//  Description : 64-bit cycle and retired-instruction counters. Both wrap
//                modulo 2^64 and clear on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  output logic [63:0] cyc_cnt,
  output logic [63:0] instret_cnt
);

  // Count every cycle out of reset, and every retirement pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt     <= 64'd0;
      instret_cnt <= 64'd0;
    end else begin
      cyc_cnt <= cyc_cnt + 64'd1;
      if (commit) begin
        instret_cnt <= instret_cnt + 64'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv_mc_sequencer.sv
// ============================================================================
//  Module      : rv_mc_sequencer
//  Description : Multi-cycle control sequencer. Fetches over a valid/ready
//                instruction port, executes, optionally performs one data
//                access, then writes back and advances the PC.
//                Optional macro YSYX_PERF_CNT_EN adds cyc_cnt/instret_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_mc_sequencer
  import rv_core_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WIDTH-1:0]     imem_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  output logic [31:0]          inst,
  input  logic                 dec_is_load,
  input  logic                 dec_is_store,
  input  logic                 dec_rf_wen,
  input  logic                 dec_illegal,
  input  logic [WIDTH-1:0]     exu_next_pc,
  input  logic [WIDTH-1:0]     exu_alu_result,
  input  logic [WIDTH-1:0]     rf_rs2,
  input  logic [WIDTH/8-1:0]   dm_wstrb_in,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_req_we,
  output logic [WIDTH-1:0]     dmem_addr,
  output logic [WIDTH-1:0]     dmem_wdata,
  output logic [WIDTH/8-1:0]   dmem_wstrb,
  input  logic                 dmem_rsp_valid,
  input  logic [WIDTH-1:0]     dmem_rsp_data,
  output logic [WIDTH-1:0]     ld_data,
  output logic                 rf_we,
  output logic [WIDTH-1:0]     pc,
  output logic                 commit,
  output logic                 halted
`ifdef YSYX_PERF_CNT_EN
  ,
  output logic [63:0]          cyc_cnt,
  output logic [63:0]          instret_cnt
`endif
);

  state_t state, state_nxt;

  assign imem_addr = pc;

  // State register; reset abandons whatever request was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobes. Strobes are forced low while reset is held so
  // nothing is requested before the first cycle out of reset.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    rf_we          = 1'b0;
    commit         = 1'b0;
    halted         = 1'b0;
    case (state)
      FETCH_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nxt = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rsp_valid) state_nxt = EXEC;
      end
      EXEC: begin
        if (dec_illegal)                     state_nxt = HALT;
        else if (dec_is_load || dec_is_store) state_nxt = MEM_REQ;
        else                                  state_nxt = WB;
      end
      MEM_REQ: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (dmem_rsp_valid) state_nxt = WB;
      end
      WB: begin
        rf_we     = dec_rf_wen & ~dec_is_store;
        commit    = 1'b1;
        state_nxt = FETCH_REQ;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = FETCH_REQ;
    endcase
    if (rst) begin
      imem_req_valid = 1'b0;
      dmem_req_valid = 1'b0;
      rf_we          = 1'b0;
      commit         = 1'b0;
    end
  end

  // Architectural and request registers. The data request is captured in
  // EXEC so it stays stable for the whole handshake regardless of EXU/RF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inst        <= NOP_INST;
      ld_data     <= '0;
      dmem_req_we <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_wstrb  <= '0;
    end else begin
      case (state)
        FETCH_WAIT: begin
          if (imem_rsp_valid) inst <= imem_rsp_data;
        end
        EXEC: begin
          dmem_req_we <= dec_is_store;
          dmem_addr   <= exu_alu_result;
          dmem_wdata  <= dec_is_store ? rf_rs2 : '0;
          dmem_wstrb  <= dec_is_store ? dm_wstrb_in : '0;
        end
        MEM_WAIT: begin
          if (dmem_rsp_valid && !dmem_req_we) ld_data <= dmem_rsp_data;
        end
        WB: begin
          pc <= exu_next_pc;
        end
        default: ;
      endcase
    end
  end

`ifdef YSYX_PERF_CNT_EN
  rv_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .commit      (commit),
    .cyc_cnt     (cyc_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  // Counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_mc_sequencer.sv
// ============================================================================
//  Module      : tb_rv_mc_sequencer
//  Description : Self-checking bench for rv_mc_sequencer. Memory ports are
//                driven transaction by transaction with random stalls; the
//                reference model tracks PC, load data, commit count and the
//                expected per-instruction cycle count (base + stalls).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_mc_sequencer;

  localparam int          W   = 32;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req_valid, imem_req_ready = 1'b0;
  logic [W-1:0]  imem_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [31:0]   imem_rsp_data = '0;
  logic [31:0]   inst;
  logic          dec_is_load = 1'b0, dec_is_store = 1'b0, dec_rf_wen = 1'b0, dec_illegal = 1'b0;
  logic [W-1:0]  exu_next_pc = '0, exu_alu_result = '0, rf_rs2 = '0;
  logic [W/8-1:0] dm_wstrb_in = '0;
  logic          dmem_req_valid, dmem_req_ready = 1'b0, dmem_req_we;
  logic [W-1:0]  dmem_addr, dmem_wdata;
  logic [W/8-1:0] dmem_wstrb;
  logic          dmem_rsp_valid = 1'b0;
  logic [W-1:0]  dmem_rsp_data = '0;
  logic [W-1:0]  ld_data, pc;
  logic          rf_we, commit, halted;
`ifdef YSYX_PERF_CNT_EN
  logic [63:0]   cyc_cnt, instret_cnt;
`endif

  rv_mc_sequencer #(.WIDTH(W), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .inst(inst),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_rf_wen(dec_rf_wen),
    .dec_illegal(dec_illegal), .exu_next_pc(exu_next_pc), .exu_alu_result(exu_alu_result),
    .rf_rs2(rf_rs2), .dm_wstrb_in(dm_wstrb_in),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
    .ld_data(ld_data), .rf_we(rf_we), .pc(pc), .commit(commit), .halted(halted)
`ifdef YSYX_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Observed commit pulses since the last reset.
  int unsigned commits_seen = 0;
  always @(negedge clk) begin
    if (rst) commits_seen = 0;
    else if (commit) commits_seen = commits_seen + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference model state.
  logic [31:0] m_pc = RPC;
  logic [31:0] m_ld = '0;
  int unsigned m_commits = 0;

  // Per-instruction operands, set by the caller before run_instr.
  logic [31:0] g_iw, g_ea, g_sd, g_ldv;
  logic [3:0]  g_st;

  task automatic randomize_operands();
    g_iw  = $urandom;
    g_ea  = $urandom;
    g_sd  = $urandom;
    g_ldv = $urandom;
    g_st  = 4'($urandom);
  endtask

  task automatic do_reset_pulse();
    rst = 1'b1;
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, NOP);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_valids", {imem_req_valid, dmem_req_valid, rf_we, commit, halted}, 0);
    step();
    step();
    // Stale data response arriving as reset releases must be dropped.
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'hBAD0_BAD0;
    rst = 1'b0;
    m_pc = RPC;
    m_ld = '0;
    m_commits = 0;
    step();
    dmem_rsp_valid = 1'b0;
    chk("post_rst_fetch", {imem_req_valid, imem_addr}, {1'b1, RPC});
    step();
    chk("stale_rsp_dropped", ld_data, 0);
  endtask

  // kind: 0 = alu/branch, 1 = load, 2 = store, 3 = illegal
  task automatic run_instr(input int kind, input int r1, input int r2, input int d1, input int d2,
                           input logic [31:0] npc, input bit rfw, input bit abort);
    bit found;
    int unsigned start, n, exp_n;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("fetch_req_seen", found, 1);
    start = cyc;
    chk("imem_addr", imem_addr, m_pc);
    for (int i = 0; i < r1; i++) begin
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      step();
      chk("imem_hold", {imem_req_valid, imem_addr}, {1'b1, m_pc});
    end
    // Handshake cycle; a response here must be ignored.
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'($urandom_range(0, 1));
    imem_rsp_data  = ~g_iw;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("imem_one_outstanding", imem_req_valid, 0);
    for (int i = 0; i < r2; i++) step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = g_iw;
    dec_is_load    = (kind == 1);
    dec_is_store   = (kind == 2);
    dec_illegal    = (kind == 3);
    dec_rf_wen     = rfw;
    exu_next_pc    = npc;
    exu_alu_result = g_ea;
    rf_rs2         = g_sd;
    dm_wstrb_in    = g_st;
    step();
    chk("inst", inst, g_iw);
    // Spurious fetch response during EXEC.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = ~g_iw;
    step();
    imem_rsp_valid = 1'b0;
    if (kind == 3) begin
      chk("halted", halted, 1);
`ifdef YSYX_PERF_CNT_EN
      begin
        logic [63:0] c0;
        c0 = cyc_cnt;
        for (int i = 0; i < 10; i++) begin
          step();
          chk("halt_quiet", {imem_req_valid, dmem_req_valid, commit, halted}, 4'b0001);
        end
        chk("cyc_cnt_in_halt", cyc_cnt, c0 + 64'd10);
      end
`else
      for (int i = 0; i < 10; i++) begin
        step();
        chk("halt_quiet", {imem_req_valid, dmem_req_valid, commit, halted}, 4'b0001);
      end
`endif
      return;
    end
    if (kind != 0) begin
      // Scramble sources: the request must keep its EXEC-time values.
      exu_alu_result = $urandom;
      rf_rs2         = $urandom;
      dm_wstrb_in    = 4'($urandom);
      chk("dmem_req", {dmem_req_valid, dmem_req_we}, {1'b1, kind == 2});
      chk("dmem_addr", dmem_addr, g_ea);
      chk("dmem_wstrb", dmem_wstrb, (kind == 2) ? g_st : 4'h0);
      if (kind == 2) chk("dmem_wdata", dmem_wdata, g_sd);
      for (int i = 0; i < d1; i++) begin
        dmem_rsp_valid = 1'($urandom_range(0, 1));
        dmem_rsp_data  = $urandom;
        step();
        chk("dmem_hold", {dmem_req_valid, dmem_addr}, {1'b1, g_ea});
      end
      dmem_req_ready = 1'b1;
      dmem_rsp_valid = 1'($urandom_range(0, 1));
      dmem_rsp_data  = ~g_ldv;
      step();
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      chk("dmem_one_outstanding", dmem_req_valid, 0);
      for (int i = 0; i < d2; i++) step();
      if (abort) begin
        do_reset_pulse();
        return;
      end
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = g_ldv;
      step();
      dmem_rsp_valid = 1'b0;
      if (kind == 1) m_ld = g_ldv;
    end
    // Writeback cycle.
    n     = cyc - start + 1;
    exp_n = ((kind == 0) ? 4 : 6) + r1 + r2 + ((kind == 0) ? 0 : d1 + d2);
    chk("latency", n, exp_n);
    chk("commit", commit, 1);
    chk("rf_we", rf_we, rfw && (kind != 2));
    chk("inst_unchanged", inst, g_iw);
    m_commits++;
    step();
    m_pc = npc;
    chk("pc", pc, m_pc);
    chk("ld_data", ld_data, m_ld);
    chk("commit_pulse", commit, 0);
  endtask

  initial begin
    int kind;
    logic [31:0] npc;
    // Reset state.
    step();
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, NOP);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_valids", {imem_req_valid, dmem_req_valid, rf_we, commit, halted}, 0);
    rst = 1'b0;
    step();
    chk("first_fetch", imem_req_valid, 1);

    // addi, zero-wait memory.
    randomize_operands();
    run_instr(0, 0, 0, 0, 0, RPC + 32'd4, 1'b1, 1'b0);
    // lw, ready after 3 cycles, response 2 cycles later.
    randomize_operands();
    g_ldv = 32'hDEAD_BEEF;
    run_instr(1, 0, 0, 3, 2, m_pc + 32'd4, 1'b1, 1'b0);
    // sw, full word.
    randomize_operands();
    g_sd = 32'h1234_5678;
    g_st = 4'b1111;
    run_instr(2, 0, 0, 0, 0, m_pc + 32'd4, 1'b1, 1'b0);
    // Taken branch.
    randomize_operands();
    run_instr(0, 1, 1, 0, 0, 32'h8000_0100, 1'b0, 1'b0);
    chk("branch_target", imem_addr, 32'h8000_0100);

    // Random instruction mix with random stalls and targets.
    for (int t = 0; t < 40; t++) begin
      randomize_operands();
      kind = $urandom_range(0, 2);
      npc  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : m_pc + 32'd4;
      run_instr(kind, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), npc, (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
    end
    chk("commit_count", commits_seen, m_commits);
`ifdef YSYX_PERF_CNT_EN
    chk("instret_cnt", instret_cnt, 64'(m_commits));
`endif

    // Reset while a load is waiting for its response.
    randomize_operands();
    run_instr(1, 0, 0, 1, 1, m_pc + 32'd4, 1'b1, 1'b1);
    randomize_operands();
    run_instr(0, 0, 0, 0, 0, RPC + 32'd8, 1'b1, 1'b0);
    chk("commit_count_after_rst", commits_seen, m_commits);
`ifdef YSYX_PERF_CNT_EN
    chk("instret_cnt_after_rst", instret_cnt, 64'(m_commits));
`endif

    // Illegal instruction halts the core.
    randomize_operands();
    run_instr(3, 0, 0, 0, 0, m_pc + 32'd4, 1'b0, 1'b0);
    chk("halt_pc_frozen", pc, m_pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
